// File: rtl/rf_access_ctrl_if.sv
// Request/response bus between a requester and rf_access_ctrl.
// Request: req_valid/req_ready handshake carrying write flag, two addresses and write data.
// Response: rsp_valid/rsp_ready handshake carrying write echo and two read data words.
interface rf_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr_a;
  logic [4:0]  req_addr_b;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_data_a;
  logic [31:0] rsp_data_b;

  // Requester side
  modport master (
    output req_valid, req_write, req_addr_a, req_addr_b, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_data_a, rsp_data_b
  );

  // Controller side
  modport slave (
    input  req_valid, req_write, req_addr_a, req_addr_b, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_data_a, rsp_data_b
  );
endinterface

// File: rtl/rf_access_ctrl.sv
// Purpose: sequences single write / dual read requests onto a register file with
//   1-cycle registered reads; one transaction in flight at a time.
// Latency: write accept -> rsp_valid after 1 edge; read accept -> rsp_valid after 2 edges.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
// Ports: clk, rst (sync active-high); bus (rf_access_ctrl_if.slave: req/rsp handshakes);
//   rf_w_data/rf_w_addr/rf_w_ena (RF write port); rf_ra_addr/rf_rb_addr out,
//   rf_ra_data/rf_rb_data in (RF read ports).
// Option: define RF_X0_ZERO_EN to make address 0 read as zero and ignore writes to it.
module rf_access_ctrl (
  input  logic               clk,
  input  logic               rst,
  rf_access_ctrl_if.slave    bus,
  output logic [31:0]        rf_w_data,
  output logic [4:0]         rf_w_addr,
  output logic               rf_w_ena,
  output logic [4:0]         rf_ra_addr,
  output logic [4:0]         rf_rb_addr,
  input  logic [31:0]        rf_ra_data,
  input  logic [31:0]        rf_rb_data
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD      = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]  state_q,  state_d;
  logic        write_q,  write_d;
  logic [4:0]  addr_a_q, addr_a_d;
  logic [4:0]  addr_b_q, addr_b_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [31:0] rsp_a_q,  rsp_a_d;
  logic [31:0] rsp_b_q,  rsp_b_d;

  // Read data as seen by the response path, with optional hardwired-zero address 0.
  logic [31:0] rd_a;
  logic [31:0] rd_b;

`ifdef RF_X0_ZERO_EN
  assign rd_a     = (addr_a_q == 5'd0) ? 32'd0 : rf_ra_data;
  assign rd_b     = (addr_b_q == 5'd0) ? 32'd0 : rf_rb_data;
  assign rf_w_ena = (state_q == WR) && (addr_a_q != 5'd0);
`else
  assign rd_a     = rf_ra_data;
  assign rd_b     = rf_rb_data;
  assign rf_w_ena = (state_q == WR);
`endif

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    wdata_d  = wdata_q;
    rsp_a_d  = rsp_a_q;
    rsp_b_d  = rsp_b_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          addr_a_d = bus.req_addr_a;
          addr_b_d = bus.req_addr_b;
          wdata_d  = bus.req_wdata;
          state_d  = bus.req_write ? WR : RD;
        end
      end
      WR: begin
        // Write acks carry zero data.
        rsp_a_d = 32'd0;
        rsp_b_d = 32'd0;
        state_d = RESP;
      end
      // RF samples the latched read addresses on the edge leaving RD.
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        rsp_a_d = rd_a;
        rsp_b_d = rd_b;
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      addr_a_q <= 5'd0;
      addr_b_q <= 5'd0;
      wdata_q  <= 32'd0;
      rsp_a_q  <= 32'd0;
      rsp_b_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      wdata_q  <= wdata_d;
      rsp_a_q  <= rsp_a_d;
      rsp_b_q  <= rsp_b_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_write  = write_q;
  assign bus.rsp_data_a = rsp_a_q;
  assign bus.rsp_data_b = rsp_b_q;

  assign rf_w_addr  = addr_a_q;
  assign rf_w_data  = wdata_q;
  assign rf_ra_addr = addr_a_q;
  assign rf_rb_addr = addr_b_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Scoreboard bench for rf_access_ctrl: directed scenarios followed by random traffic.
// A behavioural register-file model answers the DUT's RF ports; a reference memory
// predicts every response and write-port pulse, and a negedge monitor checks them.
module tb_rf_access_ctrl;

`ifdef RF_X0_ZERO_EN
  localparam bit X0_ZERO = 1'b1;
`else
  localparam bit X0_ZERO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rf_w_data;
  logic [4:0]  rf_w_addr;
  logic        rf_w_ena;
  logic [4:0]  rf_ra_addr;
  logic [4:0]  rf_rb_addr;
  logic [31:0] rf_ra_data;
  logic [31:0] rf_rb_data;
  logic        rf_clr;

  always #5 clk = ~clk;

  rf_access_ctrl_if bus ();

  rf_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .rf_w_data  (rf_w_data),
    .rf_w_addr  (rf_w_addr),
    .rf_w_ena   (rf_w_ena),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .rf_ra_data (rf_ra_data),
    .rf_rb_data (rf_rb_data)
  );

  // Register file: registered reads with write-to-read forwarding.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
    end else if (rf_w_ena) begin
      rf_mem[rf_w_addr] <= rf_w_data;
    end
    rf_ra_data <= (rf_w_ena && rf_w_addr == rf_ra_addr) ? rf_w_data : rf_mem[rf_ra_addr];
    rf_rb_data <= (rf_w_ena && rf_w_addr == rf_rb_addr) ? rf_w_data : rf_mem[rf_rb_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] b;
    int          due;
  } rsp_exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } wr_exp_t;

  rsp_exp_t    rsp_q [$];
  wr_exp_t     wr_q  [$];
  logic [31:0] ref_mem [32];
  logic        hold_rsp = 1'b0;
  logic        rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Response consumer.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_rsp)      bus.rsp_ready = 1'b0;
      else if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
      else               bus.rsp_ready = 1'b1;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a response or write pulse.
  initial begin
    logic        in_resp;
    logic        hs_prev;
    rsp_exp_t    cur;
    wr_exp_t     w;
    logic        hw;
    logic [31:0] ha, hb;
    in_resp = 1'b0;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rf_w_ena) begin
        if (wr_q.size() == 0) flag_fail("rf_w_ena_unexpected");
        else begin
          w = wr_q.pop_front();
          chk("rf_w_addr", 32'(rf_w_addr), 32'(w.addr));
          chk("rf_w_data", rf_w_data, w.data);
          chk("rf_w_cycle", 32'(cyc), 32'(w.due));
        end
      end
      if (rst) begin
        in_resp = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) begin
          chk("req_ready_after_rsp", 32'(bus.req_ready), 32'd1);
          chk("rsp_valid_after_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        hs_prev = 1'b0;
        if (bus.rsp_valid) begin
          if (!in_resp) begin
            if (rsp_q.size() == 0) flag_fail("rsp_unexpected");
            else begin
              cur = rsp_q.pop_front();
              chk("rsp_write",   32'(bus.rsp_write), 32'(cur.wr));
              chk("rsp_data_a",  bus.rsp_data_a, cur.a);
              chk("rsp_data_b",  bus.rsp_data_b, cur.b);
              chk("rsp_latency", 32'(cyc), 32'(cur.due));
            end
            in_resp = 1'b1;
            hw = bus.rsp_write;
            ha = bus.rsp_data_a;
            hb = bus.rsp_data_b;
          end else begin
            chk("rsp_write_stable",  32'(bus.rsp_write), 32'(hw));
            chk("rsp_data_a_stable", bus.rsp_data_a, ha);
            chk("rsp_data_b_stable", bus.rsp_data_b, hb);
          end
          chk("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
          if (bus.rsp_ready) begin
            hs_prev = 1'b1;
            in_resp = 1'b0;
          end
        end
      end
    end
  end

  // Presents one request, waits for acceptance, and records what must come back.
  task automatic issue(input logic wr, input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] d);
    bit       ok;
    int       n;
    rsp_exp_t e;
    wr_exp_t  w;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_addr_a = a;
    bus.req_addr_b = b;
    bus.req_wdata  = d;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
      n++;
    end
    if (!ok) flag_fail("req_accept_timeout");
    else if (wr) begin
      e.wr = 1'b1; e.a = 32'd0; e.b = 32'd0; e.due = cyc + 2;
      rsp_q.push_back(e);
      if (!(X0_ZERO && a == 5'd0)) begin
        ref_mem[a] = d;
        w.addr = a; w.data = d; w.due = cyc + 1;
        wr_q.push_back(w);
      end
    end else begin
      e.wr  = 1'b0;
      e.a   = (X0_ZERO && a == 5'd0) ? 32'd0 : ref_mem[a];
      e.b   = (X0_ZERO && b == 5'd0) ? 32'd0 : ref_mem[b];
      e.due = cyc + 3;
      rsp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || bus.rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) flag_fail("drain_timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [4:0]  a, b;
    logic [31:0] d;
    logic        wr;
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    rst            = 1'b1;
    rf_clr         = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr_a = 5'd0;
    bus.req_addr_b = 5'd0;
    bus.req_wdata  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    rf_clr = 1'b0;
    @(negedge clk);
    chk("reset_req_ready",  32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    chk("reset_rf_w_ena",   32'(rf_w_ena), 32'd0);
    chk("reset_rf_w_addr",  32'(rf_w_addr), 32'd0);
    chk("reset_rf_w_data",  rf_w_data, 32'd0);
    chk("reset_rsp_data_a", bus.rsp_data_a, 32'd0);

    // Basic write then dual read.
    issue(1'b1, 5'd5, 5'd0, 32'hDEADBEEF);
    issue(1'b1, 5'd7, 5'd0, 32'h12345678);
    issue(1'b0, 5'd5, 5'd7, 32'h0);
    wait_idle();

    // Backpressure: response held for 10 cycles, same address on both ports.
    hold_rsp = 1'b1;
    issue(1'b0, 5'd7, 5'd7, 32'h0);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) flag_fail("hold_rsp_timeout");
    repeat (10) @(negedge clk);
    chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    hold_rsp = 1'b0;
    wait_idle();

    // Address 0 behaviour.
    issue(1'b1, 5'd0, 5'd0, 32'hFFFFFFFF);
    issue(1'b0, 5'd0, 5'd0, 32'h0);
    wait_idle();

    // Reset while in WR: RF still takes the write on that edge, no response follows.
    issue(1'b1, 5'd9, 5'd0, 32'hA5A5_0009);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_q.delete();
    @(negedge clk);
    chk("rstwr_rf_w_ena",   32'(rf_w_ena), 32'd0);
    chk("rstwr_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    chk("rstwr_req_ready",  32'(bus.req_ready), 32'd1);
    chk("rstwr_rf_w_addr",  32'(rf_w_addr), 32'd0);
    chk("rstwr_rsp_data_a", bus.rsp_data_a, 32'd0);
    issue(1'b0, 5'd9, 5'd5, 32'h0);
    wait_idle();

    // Random traffic with random response backpressure.
    rand_rdy = 1'b1;
    for (int t = 0; t < 150; t++) begin
      wr = $urandom_range(0, 1) == 1;
      a  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      b  = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      d  = $urandom;
      issue(wr, a, b, d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);
    if (wr_q.size() != 0) flag_fail("rf_write_missing");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_access_ctrl.md
RF_ACCESS_CTRL -- requirements
Module: rf_access_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req_valid  in  1  request present.
REQ-004 SHALL have ports: req_ready  out  1  request accepted when both high at an edge.
REQ-005 SHALL have ports: req_write  in  1  1 = write, 0 = dual read.
REQ-006 SHALL have ports: req_addr_a  in  5  write address, or read port A address.
REQ-007 SHALL have ports: req_addr_b  in  5  read port B address, ignored on write.
REQ-008 SHALL have ports: req_wdata  in  32  write data.
REQ-009 SHALL have ports: rsp_valid  out  1  response present.
REQ-010 SHALL have ports: rsp_ready  in  1  response consumed when both high at an edge.
REQ-011 SHALL have ports: rsp_write  out  1  echo of req_write for this response.
REQ-012 SHALL have ports: rsp_data_a / rsp_data_b  out  32 each  read results, 0 for write acks.
REQ-013 SHALL have ports: rf_w_data  out  32, rf_w_addr  out  5, rf_w_ena  out  1  register-file write port.
REQ-014 SHALL have ports: rf_ra_addr / rf_rb_addr  out  5 each, rf_ra_data / rf_rb_data  in  32 each  register-file read ports.
REQ-015 SHALL drive a register file with 1-cycle registered reads and write-to-read forwarding.

Function
REQ-016 SHALL implement FSM states IDLE, WR, RD, RD_WAIT, RESP.
REQ-017 SHALL assert req_ready only in IDLE; handshake in IDLE latches req_write/addr_a/addr_b/wdata.
- Next state: WR if req_write, else RD.
REQ-018 SHALL drive rf_ra_addr/rf_rb_addr/rf_w_addr/rf_w_data from latched request registers; they hold their last value outside transactions.
REQ-019 SHALL assert rf_w_ena in state WR only, exactly one cycle, decoded from state.
- WR -> RESP unconditionally.
REQ-020 SHALL move RD -> RD_WAIT (RF samples addresses at that edge).
- RD_WAIT -> RESP, capturing rf_ra_data/rf_rb_data into rsp_data_a/b at that edge.
REQ-021 SHALL assert rsp_valid only in RESP.
- rsp_data_*, rsp_write stable while rsp_valid high.
- Write acks: rsp_data_a = rsp_data_b = 0.
REQ-022 SHALL leave RESP to IDLE on the edge where rsp_valid && rsp_ready; SHALL hold RESP indefinitely otherwise (backpressure).
REQ-023 SHALL give latency: write accept edge -> rsp_valid high after 1 edge; read accept edge -> rsp_valid high after 2 edges.
REQ-024 SHALL accept no new request until the response handshake completes; max throughput 1 write per 3 cycles, 1 read per 4.
REQ-025 SHALL permit addr_a == addr_b; both outputs carry the same value.

Reset
REQ-026 SHALL on rst at any edge, including mid-WR/RD/RESP: state IDLE, rsp_valid=0, rf_w_ena=0 in the following cycle, all address/data/rsp registers = 0.
- An in-flight transaction is dropped with no response.
REQ-027 SHALL present req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL honour macro RF_X0_ZERO_EN.
- Defined: a write to address 0 keeps rf_w_ena low in WR but still acks.
- Defined: a read port whose latched address is 0 returns 0, regardless of RF data.
REQ-029 SHALL, with RF_X0_ZERO_EN undefined, treat address 0 as an ordinary register.

Verification
REQ-030 Write 0xDEADBEEF to addr 5 -> rf_w_ena high one cycle with rf_w_addr=5, rf_w_data=0xDEADBEEF; rsp_valid one edge later with rsp_write=1, data 0.
REQ-031 Read a=5, b=7 after writing 5=0xDEADBEEF, 7=0x12345678 -> rsp_valid 2 edges after accept, rsp_data_a=0xDEADBEEF, rsp_data_b=0x12345678.
REQ-032 Hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid and data stable, req_ready=0 throughout; release -> IDLE, req_ready=1 next cycle.
REQ-033 Assert rst during WR -> rf_w_ena low next cycle, no rsp_valid, register unchanged or written only if the RF edge already sampled; req_ready=1 after reset.
REQ-034 With RF_X0_ZERO_EN: write 0xFFFFFFFF to addr 0 then read a=0, b=0 -> rf_w_ena never high, both data 0; without the macro -> both 0xFFFFFFFF.
